// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with prescaler and one-shot or
// periodic reload. Expiry is flagged with a single-cycle registered pulse.
module down_timer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  stop,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  load_periodic,
  input  logic [PRESCALE_W-1:0] load_prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expired
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                  state_q,    state_d;
  logic [WIDTH-1:0]        count_q,    count_d;
  logic [WIDTH-1:0]        reload_q,   reload_d;
  logic [PRESCALE_W-1:0]   presc_q,    presc_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic                    periodic_q, periodic_d;
  logic                    expired_q,  expired_d;
  logic                    tick_c;

  // Handshake is combinational so software sees readiness in the same cycle.
  assign load_ready = (state_q == IDLE) && !stop;

  // A tick fires on the enabled cycle where the prescaler reaches its limit.
  assign tick_c = (state_q == RUN) && enable && (presc_q == prescale_q);

  // Next-state logic: stop outranks both tick and load.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    presc_d    = presc_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    expired_d  = 1'b0;

    if (stop) begin
      state_d = IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            count_d    = load_value;
            reload_d   = load_value;
            periodic_d = load_periodic;
            prescale_d = load_prescale;
            presc_d    = '0;
            // A zero interval expires immediately and never enters RUN.
            if (load_value == '0) begin
              expired_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (enable) begin
            if (tick_c) begin
              presc_d = '0;
              if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
              end else if (count_q == WIDTH'(1)) begin
                expired_d = 1'b1;
                if (periodic_q) begin
                  count_d = reload_q;
                end else begin
                  count_d = '0;
                  state_d = IDLE;
                end
              end
            end else begin
              presc_d = presc_q + PRESCALE_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; reset mid-run discards any pending expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      presc_q    <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      presc_q    <= presc_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      expired_q  <= expired_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == RUN);
  assign expired = expired_q;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: scoreboard bench for down_timer. Expected observations are
// queued as stimulus is driven and compared one per clock after each edge.
module tb_down_timer;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned PRESCALE_W = 8;

  logic                  clk;
  logic                  reset_n;
  logic                  enable;
  logic                  stop;
  logic                  load_valid;
  logic                  load_ready;
  logic [WIDTH-1:0]      load_value;
  logic                  load_periodic;
  logic [PRESCALE_W-1:0] load_prescale;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  expired;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] cnt;
    logic             bsy;
    logic             exp;
    logic             rdy;
  } obs_t;

  obs_t sb_q[$];
  int   n_checks;
  int   n_pass;

  down_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .stop          (stop),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_value    (load_value),
    .load_periodic (load_periodic),
    .load_prescale (load_prescale),
    .count         (count),
    .busy          (busy),
    .expired       (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] cnt,
                      input logic bsy, input logic exp, input logic rdy);
    obs_t o;
    o.tag = tag; o.cnt = cnt; o.bsy = bsy; o.exp = exp; o.rdy = rdy;
    sb_q.push_back(o);
  endtask

  // Advance one edge, then compare the oldest queued expectation.
  task automatic step();
    obs_t o;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty: no expectation queued at %0t", $time);
    end else begin
      o = sb_q.pop_front();
      check({o.tag, "_count"},   count,              o.cnt);
      check({o.tag, "_busy"},    WIDTH'(busy),       WIDTH'(o.bsy));
      check({o.tag, "_expired"}, WIDTH'(expired),    WIDTH'(o.exp));
      check({o.tag, "_ready"},   WIDTH'(load_ready), WIDTH'(o.rdy));
    end
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v, input logic per,
                         input logic [PRESCALE_W-1:0] ps);
    load_valid    = 1'b1;
    load_value    = v;
    load_periodic = per;
    load_prescale = ps;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0;
    reset_n = 1'b0; enable = 1'b0; stop = 1'b0; load_valid = 1'b0;
    load_value = '0; load_periodic = 1'b0; load_prescale = '0;

    // Reset defaults
    #12;
    check("rst_count",   count,              '0);
    check("rst_busy",    WIDTH'(busy),       '0);
    check("rst_expired", WIDTH'(expired),    '0);
    check("rst_ready",   WIDTH'(load_ready), WIDTH'(1));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // One-shot: 3,2,1,0 on consecutive edges
    enable = 1'b1;
    do_load(3, 1'b0, 0);
    push("os_acc", 3, 1, 0, 0); step();
    load_valid = 1'b0;
    push("os_2", 2, 1, 0, 0); step();
    push("os_1", 1, 1, 0, 0); step();
    push("os_0", 0, 0, 1, 1); step();
    push("os_idle", 0, 0, 0, 1); step();

    // Prescale 3 with a 5-cycle enable gap: expiry 13 edges after accept
    do_load(2, 1'b0, 3);
    push("ps_acc", 2, 1, 0, 0); step();
    load_valid = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      enable = !(i >= 6 && i <= 10);
      if (i < 4)       push("ps_a", 2, 1, 0, 0);
      else if (i < 13) push("ps_b", 1, 1, 0, 0);
      else             push("ps_exp", 0, 0, 1, 1);
      step();
    end
    enable = 1'b1;
    push("ps_idle", 0, 0, 0, 1); step();

    // Periodic reload of 4: expired every 4 edges for 3 periods
    do_load(4, 1'b1, 0);
    push("per_acc", 4, 1, 0, 0); step();
    load_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i % 4 == 0) push("per_rl", 4, 1, 1, 0);
      else            push("per_dn", WIDTH'(4 - (i % 4)), 1, 0, 0);
      step();
    end
    stop = 1'b1;
    push("per_stop", 4, 0, 0, 0); step();
    stop = 1'b0;
    push("per_idle", 4, 0, 0, 1); step();

    // Zero load: single expiry pulse, stays idle, periodic ignored
    do_load(0, 1'b1, 0);
    push("z_acc", 0, 0, 1, 1); step();
    load_valid = 1'b0;
    push("z_idle", 0, 0, 0, 1); step();
    push("z_idle2", 0, 0, 0, 1); step();

    // Max load; load requests during RUN are ignored
    do_load(32'hFFFF_FFFF, 1'b0, 0);
    push("max_acc", 32'hFFFF_FFFF, 1, 0, 0); step();
    do_load(5, 1'b1, 0);
    push("max_t1", 32'hFFFF_FFFE, 1, 0, 0); step();
    push("max_t2", 32'hFFFF_FFFD, 1, 0, 0); step();
    load_valid = 1'b0;
    stop = 1'b1;
    push("max_stop", 32'hFFFF_FFFD, 0, 0, 0); step();
    stop = 1'b0;

    // Stop beats the expiring tick and a simultaneous load
    do_load(2, 1'b0, 0);
    push("sp_acc", 2, 1, 0, 0); step();
    load_valid = 1'b0;
    push("sp_1", 1, 1, 0, 0); step();
    stop = 1'b1;
    do_load(7, 1'b0, 0);
    push("sp_stop", 1, 0, 0, 0); step();
    stop = 1'b0;
    push("sp_reacc", 7, 1, 0, 0); step();
    load_valid = 1'b0;
    stop = 1'b1;
    push("sp_end", 7, 0, 0, 0); step();
    stop = 1'b0;

    // Asynchronous reset mid-run at count 5
    do_load(9, 1'b0, 0);
    push("ar_acc", 9, 1, 0, 0); step();
    load_valid = 1'b0;
    for (int i = 8; i >= 5; i--) begin
      push("ar_dn", WIDTH'(i), 1, 0, 0);
      step();
    end
    reset_n = 1'b0;
    #1;
    check("ar_count",   count,              '0);
    check("ar_busy",    WIDTH'(busy),       '0);
    check("ar_expired", WIDTH'(expired),    '0);
    check("ar_ready",   WIDTH'(load_ready), WIDTH'(1));
    check("sb_left",    WIDTH'(sb_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
